// File: rtl/slm_cmd_sequencer.sv
// Host command sequencer for the SLM board.
// Decodes UART frames ('r' reset, 'w' addr data write, 'q' addr read) and
// launches one SPI transaction per frame. The outcome goes back to the host
// as one reply byte. Frame gaps and SPI waits are guarded by a timeout counter.
module slm_cmd_sequencer #(
  parameter int TIMEOUT_CLKS = 5000000,
  parameter int CNT_W        = 23
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  input  logic       i_spi_done,
  input  logic [7:0] i_spi_rx_byte,
  input  logic       i_tx_active,
  output logic       o_spi_start,
  output logic [7:0] o_spi_addr,
  output logic [7:0] o_spi_data,
  output logic       o_tx_dv,
  output logic [7:0] o_tx_byte,
  output logic       o_reset_cmd,
  output logic       o_err,
  output logic       o_busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GET_ADDR  = 3'd1;
  localparam logic [2:0] S_GET_DATA  = 3'd2;
  localparam logic [2:0] S_SPI_START = 3'd3;
  localparam logic [2:0] S_SPI_WAIT  = 3'd4;
  localparam logic [2:0] S_TX_REPLY  = 3'd5;

  localparam logic [7:0] CMD_RESET = 8'h72;
  localparam logic [7:0] CMD_WRITE = 8'h77;
  localparam logic [7:0] CMD_READ  = 8'h71;
  localparam logic [7:0] RPL_BAD   = 8'h3F;
  localparam logic [7:0] RPL_ACK   = 8'h6B;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] to_cnt;
  logic             op_rd;
  logic             timed;
  logic             timeout;
  logic             err_nxt;
  logic             is_cmd;

  assign timed   = (state == S_GET_ADDR) || (state == S_GET_DATA) || (state == S_SPI_WAIT);
  assign timeout = (to_cnt == TO_LAST);
  assign is_cmd  = (i_rx_byte == CMD_RESET) || (i_rx_byte == CMD_WRITE) ||
                   (i_rx_byte == CMD_READ);

  // Next-state and error decision; a received byte always beats a timeout.
  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_rx_dv) begin
          if ((i_rx_byte == CMD_WRITE) || (i_rx_byte == CMD_READ)) begin
            state_nxt = S_GET_ADDR;
          end else if (!is_cmd) begin
            state_nxt = S_TX_REPLY;
            err_nxt   = 1'b1;
          end
        end
      end
      S_GET_ADDR: begin
        if (i_rx_dv) begin
          state_nxt = op_rd ? S_SPI_START : S_GET_DATA;
        end else if (timeout) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end
      end
      S_GET_DATA: begin
        if (i_rx_dv) begin
          state_nxt = S_SPI_START;
        end else if (timeout) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end
      end
      S_SPI_START: begin
        state_nxt = S_SPI_WAIT;
        err_nxt   = i_rx_dv;
      end
      S_SPI_WAIT: begin
        err_nxt = i_rx_dv;
        if (i_spi_done) begin
          state_nxt = S_TX_REPLY;
        end else if (timeout) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end
      end
      S_TX_REPLY: begin
        err_nxt = i_rx_dv;
        if (!i_tx_active) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, timeout counter, latched frame fields and registered strobes.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= S_IDLE;
      to_cnt      <= '0;
      op_rd       <= 1'b0;
      o_spi_start <= 1'b0;
      o_spi_addr  <= 8'h00;
      o_spi_data  <= 8'h00;
      o_tx_dv     <= 1'b0;
      o_tx_byte   <= 8'h00;
      o_reset_cmd <= 1'b0;
      o_err       <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_busy      <= (state_nxt != S_IDLE);
      o_err       <= err_nxt;
      o_spi_start <= (state == S_SPI_START);
      o_tx_dv     <= (state == S_TX_REPLY) && !i_tx_active;
      o_reset_cmd <= (state == S_IDLE) && i_rx_dv && (i_rx_byte == CMD_RESET);
      // Counter restarts on any state change; accepted bytes always change state.
      if ((state_nxt != state) || !timed) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (i_rx_dv) begin
            op_rd <= (i_rx_byte == CMD_READ);
            if (!is_cmd) begin
              o_tx_byte <= RPL_BAD;
            end
          end
        end
        S_GET_ADDR: begin
          if (i_rx_dv) begin
            o_spi_addr <= {op_rd, i_rx_byte[6:0]};
            if (op_rd) begin
              o_spi_data <= 8'h00;
            end
          end
        end
        S_GET_DATA: begin
          if (i_rx_dv) begin
            o_spi_data <= i_rx_byte;
          end
        end
        S_SPI_WAIT: begin
          if (i_spi_done) begin
            o_tx_byte <= op_rd ? i_spi_rx_byte : RPL_ACK;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slm_cmd_sequencer.sv
// Bench for slm_cmd_sequencer: transaction-level stimulus pushes expected
// strobes (value + cycle) into per-output queues; a negedge monitor pops them.
module tb_slm_cmd_sequencer;

  localparam int TO = 16;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       i_rx_dv;
  logic [7:0] i_rx_byte;
  logic       i_spi_done;
  logic [7:0] i_spi_rx_byte;
  logic       i_tx_active;
  logic       o_spi_start;
  logic [7:0] o_spi_addr;
  logic [7:0] o_spi_data;
  logic       o_tx_dv;
  logic [7:0] o_tx_byte;
  logic       o_reset_cmd;
  logic       o_err;
  logic       o_busy;

  typedef struct {
    logic [15:0] v;
    int          cyc;
  } exp_t;

  exp_t q_spi[$];
  exp_t q_tx[$];
  exp_t q_rst[$];
  exp_t q_err[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  slm_cmd_sequencer #(.TIMEOUT_CLKS(TO), .CNT_W(5)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_rx_dv      (i_rx_dv),
    .i_rx_byte    (i_rx_byte),
    .i_spi_done   (i_spi_done),
    .i_spi_rx_byte(i_spi_rx_byte),
    .i_tx_active  (i_tx_active),
    .o_spi_start  (o_spi_start),
    .o_spi_addr   (o_spi_addr),
    .o_spi_data   (o_spi_data),
    .o_tx_dv      (o_tx_dv),
    .o_tx_byte    (o_tx_byte),
    .o_reset_cmd  (o_reset_cmd),
    .o_err        (o_err),
    .o_busy       (o_busy)
  );

  always #5 i_clock = ~i_clock;

  always @(posedge i_clock) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [15:0] v, input int c);
    exp_t r;
    r.v   = v;
    r.cyc = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  task automatic chk_cyc(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s: seen at cycle %0d, required cycle %0d", name, got, req);
    end
  endtask

  task automatic unexp(input string name, input logic [15:0] got);
    checks++;
    failures++;
    $display("FAIL %s: strobe at cycle %0d value %h, required none", name, cyc, got);
  endtask

  // Monitor: every strobe must match the oldest expectation of its kind.
  always @(negedge i_clock) begin : mon
    exp_t e;
    if (i_reset === 1'b0) begin
      if (o_spi_start) begin
        if (q_spi.size() == 0) unexp("spi_start", {o_spi_addr, o_spi_data});
        else begin
          e = q_spi.pop_front();
          chk("spi_addr_data", {o_spi_addr, o_spi_data}, e.v);
          chk_cyc("spi_start_cycle", cyc, e.cyc);
        end
      end
      if (o_tx_dv) begin
        if (q_tx.size() == 0) unexp("tx_dv", {8'h00, o_tx_byte});
        else begin
          e = q_tx.pop_front();
          chk("tx_byte", {8'h00, o_tx_byte}, e.v);
          chk_cyc("tx_dv_cycle", cyc, e.cyc);
        end
      end
      if (o_reset_cmd) begin
        if (q_rst.size() == 0) unexp("reset_cmd", 16'h0);
        else begin
          e = q_rst.pop_front();
          chk_cyc("reset_cmd_cycle", cyc, e.cyc);
        end
      end
      if (o_err) begin
        if (q_err.size() == 0) unexp("err", 16'h0);
        else begin
          e = q_err.pop_front();
          chk_cyc("err_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  function automatic int pending();
    return q_spi.size() + q_tx.size() + q_rst.size() + q_err.size();
  endfunction

  task automatic send(input logic [7:0] b, output int t);
    i_rx_dv   = 1'b1;
    i_rx_byte = b;
    t         = cyc;
    tick();
    i_rx_dv   = 1'b0;
    i_rx_byte = 8'($urandom);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (pending() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected strobes missing after %0d cycles, required 0",
               pending(), budget);
      q_spi.delete(); q_tx.delete(); q_rst.delete(); q_err.delete();
    end
    tick();
    chk("busy_idle", {15'h0, o_busy}, 16'h0);
  endtask

  task automatic spi_finish(input logic [7:0] rxb, input logic [7:0] reply, input int hold);
    int d = cyc;
    q_tx.push_back(mk({8'h00, reply}, (hold == 0) ? d + 2 : d + hold + 1));
    i_spi_done    = 1'b1;
    i_spi_rx_byte = rxb;
    i_tx_active   = (hold > 0);
    tick();
    i_spi_done = 1'b0;
    for (int i = 1; i < hold; i++) tick();
    i_tx_active = 1'b0;
  endtask

  task automatic frame(input bit rd, input logic [7:0] ab, input logic [7:0] db,
                       input logic [7:0] rxb, input int gap, input int inj, input int hold);
    int t;
    logic [7:0] a_exp;
    logic [7:0] d_exp;
    send(rd ? 8'h71 : 8'h77, t);
    chk("busy_in_frame", {15'h0, o_busy}, 16'h1);
    send(ab, t);
    if (!rd) send(db, t);
    a_exp = {rd, ab[6:0]};
    d_exp = rd ? 8'h00 : db;
    q_spi.push_back(mk({a_exp, d_exp}, t + 2));
    for (int i = 0; i < gap; i++) begin
      if (i == inj) begin
        i_rx_dv   = 1'b1;
        i_rx_byte = 8'($urandom);
        q_err.push_back(mk(16'h0, cyc + 1));
      end
      tick();
      i_rx_dv = 1'b0;
    end
    spi_finish(rxb, rd ? rxb : 8'h6B, hold);
    wait_drain(40);
  endtask

  task automatic bad_cmd(input logic [7:0] b);
    int t;
    send(b, t);
    q_err.push_back(mk(16'h0, t + 1));
    q_tx.push_back(mk({8'h00, 8'h3F}, t + 2));
    wait_drain(20);
  endtask

  task automatic reset_cmd();
    int t;
    send(8'h72, t);
    q_rst.push_back(mk(16'h0, t + 1));
    wait_drain(20);
  endtask

  initial begin
    int t;
    int gap;
    int inj;
    logic [7:0] b;
    i_reset = 1'b1; i_rx_dv = 1'b0; i_rx_byte = 8'h00; i_spi_done = 1'b0;
    i_spi_rx_byte = 8'h00; i_tx_active = 1'b0;
    repeat (3) tick();
    chk("reset_strobes", {11'h0, o_spi_start, o_tx_dv, o_reset_cmd, o_err, o_busy}, 16'h0);
    chk("reset_addr_data", {o_spi_addr, o_spi_data}, 16'h0);
    chk("reset_tx_byte", {8'h00, o_tx_byte}, 16'h0);
    i_reset = 1'b0;
    tick();

    // Directed write and read with tx_active back-pressure.
    frame(1'b0, 8'hC9, 8'h32, 8'hA5, 3, -1, 0);
    frame(1'b1, 8'h09, 8'h00, 8'h32, 3, -1, 5);
    reset_cmd();
    bad_cmd(8'h41);
    // 'r' inside a frame is plain data.
    frame(1'b0, 8'h72, 8'h72, 8'h00, 2, -1, 0);

    // Timeout in GET_ADDR, GET_DATA and SPI_WAIT.
    send(8'h77, t);
    q_err.push_back(mk(16'h0, t + 1 + TO));
    wait_drain(30);
    send(8'h77, t);
    send(8'h10, t);
    q_err.push_back(mk(16'h0, t + 1 + TO));
    wait_drain(30);
    send(8'h71, t);
    send(8'h22, t);
    q_spi.push_back(mk({8'hA2, 8'h00}, t + 2));
    q_err.push_back(mk(16'h0, t + 2 + TO));
    wait_drain(40);

    // Byte arriving exactly when the timeout would fire is accepted.
    send(8'h77, t);
    send(8'h05, t);
    repeat (TO - 1) tick();
    send(8'h5A, t);
    q_spi.push_back(mk({8'h05, 8'h5A}, t + 2));
    tick();
    spi_finish(8'h00, 8'h6B, 0);
    wait_drain(20);

    // Byte during SPI_WAIT errors but the transaction completes.
    frame(1'b0, 8'h33, 8'h44, 8'h00, 6, 3, 2);

    // Reset while waiting for SPI: late done yields nothing.
    send(8'h77, t);
    send(8'h11, t);
    send(8'h99, t);
    q_spi.push_back(mk({8'h11, 8'h99}, t + 2));
    tick(); tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("midreset_strobes", {11'h0, o_spi_start, o_tx_dv, o_reset_cmd, o_err, o_busy}, 16'h0);
    chk("midreset_addr_data", {o_spi_addr, o_spi_data}, 16'h0);
    i_spi_done = 1'b1;
    i_spi_rx_byte = 8'h77;
    tick();
    i_spi_done = 1'b0;
    repeat (4) tick();
    chk("postreset_strobes", {11'h0, o_spi_start, o_tx_dv, o_reset_cmd, o_err, o_busy}, 16'h0);
    chk("postreset_tx_byte", {8'h00, o_tx_byte}, 16'h0);
    wait_drain(5);

    // Randomized mix of commands.
    for (int k = 0; k < 40; k++) begin
      gap = int'($urandom_range(1, 10));
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, gap - 1)) : -1;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: frame(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), gap, -1,
                          int'($urandom_range(0, 6)));
        4, 5, 6:    frame(1'b1, 8'($urandom), 8'h00, 8'($urandom), gap, inj,
                          int'($urandom_range(0, 6)));
        7:          reset_cmd();
        8: begin
          b = 8'($urandom);
          while (b == 8'h72 || b == 8'h77 || b == 8'h71) b = 8'($urandom);
          bad_cmd(b);
        end
        default:    frame(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), gap, inj,
                          int'($urandom_range(0, 6)));
      endcase
    end

    wait_drain(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
